// File: rtl/sti4_ti_stage_seq.sv
// Share-pipeline controller for the 4-bit threshold-implemented S-box: holds three
// 4-bit shares, steps them through NSTAGE external array stages, returns them on valid/ready.
// Optional build macro STI4_SHARE_REFRESH_EN adds fresh-mask share refresh at each stage capture.
module sti4_ti_stage_seq #(
  parameter int NSTAGE = 2,
  parameter int STW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [11:0]    in_sh,
  input  logic [7:0]     rnd,
  output logic [11:0]    sh_bus,
  output logic [STW-1:0] stage_idx,
  input  logic [11:0]    comp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [11:0]    out_sh
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [STW-1:0] LAST_STAGE = STW'(NSTAGE - 1);

  state_t         state_reg, state_next;
  logic [11:0]    share_reg, share_next;
  logic [STW-1:0] cnt_reg, cnt_next;
  logic [11:0]    capture;

`ifdef STI4_SHARE_REFRESH_EN
  // Mask {r0^r1, r1, r0} XORs to zero across the shares, so the unshared value is untouched.
  logic [3:0]  r0;
  logic [3:0]  r1;
  logic [11:0] mask;

  assign r0      = rnd[3:0];
  assign r1      = rnd[7:4];
  assign mask    = {r0 ^ r1, r1, r0};
  assign capture = comp ^ mask;
`else
  logic unused_rnd;

  assign unused_rnd = ^rnd;
  assign capture    = comp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      share_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      share_reg <= share_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    share_next = share_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          share_next = in_sh;
          cnt_next   = '0;
          state_next = EVAL;
        end
      end
      EVAL: begin
        // Registering every stage result is the glitch barrier between decomposition stages.
        share_next = capture;
        if (cnt_reg == LAST_STAGE) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        share_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // cnt is held at zero outside EVAL, so it can drive the stage select directly.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sh_bus    = share_reg;
  assign stage_idx = cnt_reg;
  assign out_sh    = share_reg;

endmodule

// File: tb/tb_sti4_ti_stage_seq.sv
// Randomized bench for sti4_ti_stage_seq: a transaction-level model predicts every output
// each cycle; a share-level array model (quadratic TI cells) stands in for the component array.
module tb_sti4_ti_stage_seq;
  localparam int NST = 2;
  localparam int STW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [11:0]    in_sh;
  logic [7:0]     rnd;
  logic [11:0]    sh_bus;
  logic [STW-1:0] stage_idx;
  logic [11:0]    comp;
  logic           out_valid;
  logic           out_ready;
  logic [11:0]    out_sh;

  bit arr_ti   = 1'b0;
  bit rnd_rand = 1'b0;
  bit ord_rand = 1'b0;
  bit cmp_en   = 1'b0;

  int checks = 0;
  int errors = 0;

  sti4_ti_stage_seq #(.NSTAGE(NST), .STW(STW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sh(in_sh),
    .rnd(rnd), .sh_bus(sh_bus), .stage_idx(stage_idx), .comp(comp),
    .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] xor3(input logic [11:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction

  // Unshared reference: stage 0 then stage 1 applied to the plain 4-bit value.
  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [3:0] y;
    logic [3:0] z;
    for (int k = 0; k < 4; k++) y[k] = x[k] ^ (x[(k+1)%4] & x[(k+2)%4]);
    for (int k = 0; k < 4; k++) z[k] = y[(k+1)%4] ^ (y[k] & y[(k+3)%4]);
    z[3] = ~z[3];
    return z;
  endfunction

  // Share-level AND: output share j never touches input share j.
  function automatic logic [2:0] and_ti(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    r[0] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
    r[1] = (a[2] & b[2]) ^ (a[2] & b[0]) ^ (a[0] & b[2]);
    r[2] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
    return r;
  endfunction

  function automatic logic [2:0] lin_ti(input logic [2:0] a);
    return {a[0], a[2], a[1]};
  endfunction

  function automatic logic [2:0] sv_bit(input logic [11:0] sh, input int i);
    return {sh[8+i], sh[4+i], sh[i]};
  endfunction

  function automatic logic [11:0] ti_stage(input logic [11:0] sh, input int st);
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [2:0] r;
    for (int k = 0; k < 4; k++) begin
      if (st == 0) begin
        r = lin_ti(sv_bit(sh, k)) ^ and_ti(sv_bit(sh, (k+1)%4), sv_bit(sh, (k+2)%4));
      end else if (st == 1) begin
        r = lin_ti(sv_bit(sh, (k+1)%4)) ^ and_ti(sv_bit(sh, k), sv_bit(sh, (k+3)%4));
        if (k == 3) r[0] = ~r[0];
      end else begin
        r = lin_ti(sv_bit(sh, k));
      end
      c0[k] = r[0];
      c1[k] = r[1];
      c2[k] = r[2];
    end
    return {c2, c1, c0};
  endfunction

  function automatic logic [11:0] refresh(input logic [11:0] c, input logic [7:0] r);
`ifdef STI4_SHARE_REFRESH_EN
    return c ^ {r[3:0] ^ r[7:4], r[7:4], r[3:0]};
`else
    return c;
`endif
  endfunction

  always_comb comp = arr_ti ? ti_stage(sh_bus, int'(stage_idx)) : sh_bus;

  // Transaction model: phase -1 idle, 0..NST-1 evaluating stage phase, NST holding result.
  int          m_phase = -1;
  logic [11:0] m_sh = '0;
  logic [11:0] acc_q[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = -1;
      m_sh    = '0;
      acc_q.delete();
    end else if (m_phase < 0) begin
      if (in_valid) begin
        m_sh    = in_sh;
        m_phase = 0;
        acc_q.push_back(in_sh);
      end
    end else if (m_phase < NST) begin
      m_sh    = refresh(arr_ti ? ti_stage(m_sh, m_phase) : m_sh, rnd);
      m_phase = m_phase + 1;
    end else if (out_ready) begin
      m_phase = -1;
      void'(acc_q.pop_front());
      done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase < 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == NST));
      chk("stage_idx", 32'(stage_idx), (m_phase >= 0 && m_phase < NST) ? 32'(m_phase) : 32'(0));
      chk("sh_bus", 32'(sh_bus), 32'(m_sh));
      if (m_phase == NST) chk("out_sh", 32'(out_sh), 32'(m_sh));
      if (m_phase >= 0 && acc_q.size() > 0) begin
        if (!arr_ti) chk("share_xor", 32'(xor3(sh_bus)), 32'(xor3(acc_q[0])));
        else if (m_phase == NST) chk("sbox", 32'(xor3(out_sh)), 32'(ref_sbox(xor3(acc_q[0]))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rand) rnd = 8'($urandom);
    if (ord_rand) out_ready = ($urandom_range(3) != 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] held;
    logic [11:0] exp1;
    logic [11:0] exp2;
    int          base;
    rst = 1'b1; in_valid = 1'b0; in_sh = '0; out_ready = 1'b1; rnd = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_sh_bus", 32'(sh_bus), 32'h0);

    // Latency/ordering with identity array and zero randomness.
    in_sh = 12'h5A3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_stage0", 32'(stage_idx), 32'd0);
    tick();
    chk("lat_stage1", 32'(stage_idx), 32'd1);
    chk("lat_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_out_sh", 32'(out_sh), 32'h5A3);
    tick();
    chk("lat_ready_back", 32'(in_ready), 32'd1);

    // Refresh values: 123 with F0 -> {1^F, 2^F, 3} = ED3; with 3C -> {E^F, D^3, 3^C} = 1EF.
`ifdef STI4_SHARE_REFRESH_EN
    exp1 = 12'hED3; exp2 = 12'h1EF;
`else
    exp1 = 12'h123; exp2 = 12'h123;
`endif
    in_sh = 12'h123; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rnd = 8'hF0;
    tick();
    chk("refresh_cap1", 32'(sh_bus), 32'(exp1));
    rnd = 8'h3C;
    tick();
    chk("refresh_cap2", 32'(out_sh), 32'(exp2));
    chk("refresh_xor", 32'(xor3(out_sh)), 32'h0);
    tick();

    // Back-pressure in DONE with ignored input pulses.
    rnd_rand = 1'b1; out_ready = 1'b0;
    in_sh = 12'hABC; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (NST) tick();
    held = out_sh;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_sh = 12'($urandom);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(out_sh), 32'(held));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("bp_release_no_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    repeat (NST + 2) tick();

    // Reset on the edge after accept.
    in_sh = 12'hFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_sh_bus", 32'(sh_bus), 32'h0);
    chk("rst_mid_stage", 32'(stage_idx), 32'd0);
    repeat (4) tick();

    // Full sweep through the TI cell array with random back-pressure and randomness.
    arr_ti = 1'b1; ord_rand = 1'b1;
    base = done_cnt;
    for (int v = 0; v < 4096; v++) begin
      bit acc;
      int n;
      acc = 1'b0; n = 0;
      in_sh = 12'(v); in_valid = 1'b1;
      while (!acc && n < 50) begin
        acc = in_ready;
        tick();
        n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    end
    ord_rand = 1'b0; out_ready = 1'b1;
    repeat (NST + 3) tick();
    chk("sweep_count", 32'(done_cnt - base), 32'd4096);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
